alpha_fade_ctrl: RTL

//   Frame-synchronous sequencer for the fg alpha fed to the three per-channel

---
 rtl/alpha_fade_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alpha_fade_ctrl.sv
// alpha_fade_ctrl
//   Frame-synchronous sequencer for the foreground alpha driven into the
//   per-channel blenders. A fade command (target, rate) is accepted over a
//   valid/ready handshake. Alpha then steps by one toward the target once
//   every (rate+1) vsync onsets. Alpha only changes on a vsync onset, so each
//   visible frame is blended with a single alpha value.
//
// Ports
//   clk_i         pixel clock, shared with the video timing core
//   rstn_i        asynchronous reset, active low
//   vsync_i       vsync from the video timing core (polarity: VS_ACTIVE_LOW)
//   cmd_valid_i   fade command valid
//   cmd_ready_o   command accepted when cmd_valid_i && cmd_ready_o
//   cmd_target_i  target alpha
//   cmd_rate_i    frames per step, minus one
//   cmd_abort_i   stop the fade in progress, alpha holds
//   alpha_o       alpha to the blenders
//   busy_o        high while a fade is in progress
//   done_o        one-cycle pulse when the target is reached
module alpha_fade_ctrl #(
  parameter int AW            = 3,
  parameter int RW            = 4,
  parameter int ALPHA_INIT    = 7,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          vsync_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_target_i,
  input  logic [RW-1:0] cmd_rate_i,
  input  logic          cmd_abort_i,
  output logic [AW-1:0] alpha_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic {IDLE, FADE} state_t;

  localparam logic          VS_POL      = (VS_ACTIVE_LOW != 0);
  localparam logic [AW-1:0] ALPHA_RESET = AW'(ALPHA_INIT);

  state_t        state, state_nxt;
  logic [AW-1:0] alpha_q, alpha_nxt, alpha_step;
  logic [AW-1:0] tgt_q;
  logic [RW-1:0] rate_q;
  logic [RW-1:0] frame_cnt, frame_cnt_nxt;
  logic          vs_act, vs_q, tick;
  logic          accept, latch_cmd;
  logic          done_q, done_nxt;

  // One unit toward the target; the caller only uses this while alpha != target,
  // so the result can never wrap.
  function automatic logic [AW-1:0] step_toward(input logic [AW-1:0] cur,
                                                input logic [AW-1:0] tgt);
    if (tgt > cur) return cur + 1'b1;
    else           return cur - 1'b1;
  endfunction

  // Vsync onset detection: vs_q holds the previous active-high level, so tick
  // is high only in the first active cycle and a held vsync never re-ticks.
  assign vs_act = vsync_i ^ VS_POL;
  assign tick   = vs_act & ~vs_q;

  assign accept     = cmd_valid_i & (state == IDLE);
  assign alpha_step = step_toward(alpha_q, tgt_q);

  always_comb begin
    state_nxt     = state;
    alpha_nxt     = alpha_q;
    frame_cnt_nxt = frame_cnt;
    done_nxt      = 1'b0;
    latch_cmd     = 1'b0;
    case (state)
      IDLE: begin
        // A tick coinciding with the accept is deliberately not counted.
        if (accept) begin
          if (cmd_target_i == alpha_q) begin
            done_nxt = 1'b1;
          end else begin
            latch_cmd     = 1'b1;
            frame_cnt_nxt = '0;
            state_nxt     = FADE;
          end
        end
      end
      FADE: begin
        // Abort has priority over a tick in the same cycle.
        if (cmd_abort_i) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (frame_cnt == rate_q) begin
            frame_cnt_nxt = '0;
            alpha_nxt     = alpha_step;
            if (alpha_step == tgt_q) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      alpha_q   <= ALPHA_RESET;
      frame_cnt <= '0;
      vs_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      alpha_q   <= alpha_nxt;
      frame_cnt <= frame_cnt_nxt;
      vs_q      <= vs_act;
      done_q    <= done_nxt;
    end
  end

  // Command fields need no reset: they are only read in FADE, which is always
  // entered through a latch.
  always_ff @(posedge clk_i) begin
    if (latch_cmd) begin
      tgt_q  <= cmd_target_i;
      rate_q <= cmd_rate_i;
    end
  end

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state == FADE);
  assign alpha_o     = alpha_q;
  assign done_o      = done_q;

endmodule
